// File: rtl/frame_compositor.sv
// Layer-stack pixel compositor with a frame-synchronous PLAY/LOST/WIN screen FSM.
// Two-stage registered colour pipeline; inputs sampled at edge n reach VGA_* after edge n+1.
module frame_compositor #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BORDER_W     = 10,
  parameter int N_ALIEN      = 8,
  parameter int N_BULLET     = 32,
  parameter int COLOR_W      = 8,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                VGA_clk,
  input  logic                rst,
  input  logic                update,
  input  logic [9:0]          xCount,
  input  logic [9:0]          yCount,
  input  logic                ScreenSize,
  input  logic [N_ALIEN-1:0]  alien,
  input  logic [N_BULLET-1:0] bullets,
  input  logic                person,
  input  logic                lost,
  input  logic                win,
  input  logic                game_over_text,
  input  logic                win_text,
  output logic [COLOR_W-1:0]  VGA_R,
  output logic [COLOR_W-1:0]  VGA_G,
  output logic [COLOR_W-1:0]  VGA_B,
  output logic                pix_valid,
  output logic [1:0]          state_o
);

  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [9:0] X_LO = 10'(BORDER_W);
  localparam logic [9:0] X_HI = 10'(H_ACTIVE - BORDER_W);
  localparam logic [9:0] Y_LO = 10'(BORDER_W);
  localparam logic [9:0] Y_HI = 10'(V_ACTIVE - BORDER_W);

  typedef enum logic [1:0] {
    PLAY = 2'b00,
    LOST = 2'b01,
    WIN  = 2'b10
  } screen_t;

  screen_t          state;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  // LOST and WIN are terminal; only rst leaves them.
  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      state       <= PLAY;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      case (state)
        PLAY: begin
          if (update && (lost || win)) begin
            state       <= lost ? LOST : WIN;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
          end
        end
        default: begin
          if (update) begin
            if (blink_cnt == CNT_LAST) begin
              blink_cnt   <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign state_o = state;

  logic border;
  assign border = (xCount < X_LO) || (xCount >= X_HI) ||
                  (yCount < Y_LO) || (yCount >= Y_HI);

  logic    s1_border, s1_red, s1_green, s1_got, s1_wt, s1_valid, s1_phase;
  screen_t s1_state;

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      s1_border <= 1'b0;
      s1_red    <= 1'b0;
      s1_green  <= 1'b0;
      s1_got    <= 1'b0;
      s1_wt     <= 1'b0;
      s1_valid  <= 1'b0;
      s1_phase  <= 1'b0;
      s1_state  <= PLAY;
    end else begin
      s1_border <= border;
      s1_red    <= |alien;
      s1_green  <= person | (|bullets);
      s1_got    <= game_over_text;
      s1_wt     <= win_text;
      s1_valid  <= ScreenSize;
      s1_phase  <= blink_phase;
      s1_state  <= state;
    end
  end

  logic r_on, g_on, b_on;

  always_comb begin
    r_on = 1'b0;
    g_on = 1'b0;
    b_on = 1'b0;
    if (s1_valid) begin
      case (s1_state)
        PLAY: begin
          r_on = s1_border | s1_red;
          g_on = s1_border | s1_green;
          b_on = s1_border;
        end
        LOST:    r_on = ~(s1_got & s1_phase);
        WIN:     g_on = ~(s1_wt & s1_phase);
        default: ;
      endcase
    end
  end

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      pix_valid <= 1'b0;
    end else begin
      VGA_R     <= {COLOR_W{r_on}};
      VGA_G     <= {COLOR_W{g_on}};
      VGA_B     <= {COLOR_W{b_on}};
      pix_valid <= s1_valid;
    end
  end

endmodule
